// File: rtl/dsp_mac_pipe.sv
// Signed pre-add / multiply / post-add-accumulate pipeline with MULT, MAC, DOT and SUB modes.
// Latency: 3 cycles from accept to result (S1 operands, S2 product, S3 result/accumulator).
// Backpressure: a held result (out_valid & !out_ready) freezes every stage; in_ready = !out_valid | out_ready.
module dsp_mac_pipe #(
  parameter int A_W   = 18,
  parameter int B_W   = 18,
  parameter int C_W   = 48,
  parameter int P_W   = 48,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [A_W-1:0]   a,
  input  logic [B_W-1:0]   b,
  input  logic [B_W-1:0]   d,
  input  logic [C_W-1:0]   c,
  input  logic             preadd_en,
  input  logic             preadd_sub,
  input  logic [1:0]       mode,
  input  logic             clr,
  input  logic             sat_en,
  input  logic [LEN_W-1:0] dot_len,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [P_W-1:0]   p,
  output logic             ovf,
  output logic             dot_done
);

  localparam int MW = A_W + B_W + 1;  // product width
  localparam int SW = P_W + 1;        // post-adder width, one guard bit for overflow detection

  localparam logic [1:0] MODE_MULT = 2'b00;
  localparam logic [1:0] MODE_MAC  = 2'b01;
  localparam logic [1:0] MODE_DOT  = 2'b10;
  localparam logic [1:0] MODE_SUB  = 2'b11;

  // The only stall source is a result the consumer has not taken yet.
  logic adv;
  assign adv      = !(out_valid && !out_ready);
  assign in_ready = adv;

  // ---------------- S1: operand and control capture ----------------
  logic             s1_vld;
  logic [A_W-1:0]   s1_a;
  logic [B_W-1:0]   s1_b;
  logic [B_W-1:0]   s1_d;
  logic [C_W-1:0]   s1_c;
  logic             s1_preadd_en;
  logic             s1_preadd_sub;
  logic [1:0]       s1_mode;
  logic             s1_clr;
  logic             s1_sat;
  logic [LEN_W-1:0] s1_len;

  // Capture the incoming beat; a cycle without in_valid becomes a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld        <= 1'b0;
      s1_a          <= '0;
      s1_b          <= '0;
      s1_d          <= '0;
      s1_c          <= '0;
      s1_preadd_en  <= 1'b0;
      s1_preadd_sub <= 1'b0;
      s1_mode       <= MODE_MULT;
      s1_clr        <= 1'b0;
      s1_sat        <= 1'b0;
      s1_len        <= '0;
    end else if (adv) begin
      s1_vld        <= in_valid;
      s1_a          <= a;
      s1_b          <= b;
      s1_d          <= d;
      s1_c          <= c;
      s1_preadd_en  <= preadd_en;
      s1_preadd_sub <= preadd_sub;
      s1_mode       <= mode;
      s1_clr        <= clr;
      s1_sat        <= sat_en;
      s1_len        <= dot_len;
    end
  end

  // ---------------- S2: pre-add and multiply ----------------
  // Operands are sign-extended to the full product width so the modular
  // product equals the exact signed product (it always fits in MW bits).
  logic [B_W:0]  b_ext;
  logic [B_W:0]  d_ext;
  logic [B_W:0]  pre_sum;
  logic [B_W:0]  mul_op;
  logic [MW-1:0] a_wide;
  logic [MW-1:0] op_wide;
  logic [MW-1:0] m_prod;

  assign b_ext   = {s1_b[B_W-1], s1_b};
  assign d_ext   = {s1_d[B_W-1], s1_d};
  assign pre_sum = s1_preadd_sub ? (d_ext - b_ext) : (d_ext + b_ext);
  assign mul_op  = s1_preadd_en ? pre_sum : b_ext;
  assign a_wide  = {{(MW-A_W){s1_a[A_W-1]}}, s1_a};
  assign op_wide = {{(MW-B_W-1){mul_op[B_W]}}, mul_op};
  assign m_prod  = a_wide * op_wide;

  logic             s2_vld;
  logic [MW-1:0]    s2_m;
  logic [C_W-1:0]   s2_c;
  logic [1:0]       s2_mode;
  logic             s2_clr;
  logic             s2_sat;
  logic [LEN_W-1:0] s2_len;

  // Register the product alongside the controls still needed by S3.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld  <= 1'b0;
      s2_m    <= '0;
      s2_c    <= '0;
      s2_mode <= MODE_MULT;
      s2_clr  <= 1'b0;
      s2_sat  <= 1'b0;
      s2_len  <= '0;
    end else if (adv) begin
      s2_vld  <= s1_vld;
      s2_m    <= m_prod;
      s2_c    <= s1_c;
      s2_mode <= s1_mode;
      s2_clr  <= s1_clr;
      s2_sat  <= s1_sat;
      s2_len  <= s1_len;
    end
  end

  // ---------------- S3: post-add / accumulate ----------------
  logic [LEN_W-1:0] dot_cnt;   // beats of the current group already absorbed
  logic [LEN_W-1:0] dot_len_q; // group length latched on the group's first beat

  logic [SW-1:0]    m_ext;
  logic [SW-1:0]    c_ext;
  logic [SW-1:0]    acc_ext;
  logic             dot_first;
  logic [LEN_W-1:0] len_eff;
  logic [LEN_W-1:0] dot_tgt;
  logic [LEN_W-1:0] cnt_nxt;
  logic             dot_end;
  logic [SW-1:0]    base;
  logic [SW-1:0]    sum;
  logic             ovf_c;
  logic [P_W-1:0]   p_max;
  logic [P_W-1:0]   p_min;
  logic [P_W-1:0]   p_c;

  assign m_ext     = {{(SW-MW){s2_m[MW-1]}}, s2_m};
  assign c_ext     = {{(SW-C_W){s2_c[C_W-1]}}, s2_c};
  assign acc_ext   = {p[P_W-1], p};
  assign dot_first = s2_clr || (dot_cnt == '0);
  assign len_eff   = (s2_len == '0) ? LEN_W'(1) : s2_len;
  assign dot_tgt   = dot_first ? len_eff : dot_len_q;
  assign cnt_nxt   = dot_first ? LEN_W'(1) : (dot_cnt + LEN_W'(1));
  assign dot_end   = (cnt_nxt == dot_tgt);
  assign p_max     = {1'b0, {(P_W-1){1'b1}}};
  assign p_min     = {1'b1, {(P_W-1){1'b0}}};

  // Select the post-adder's other operand: C, the running accumulator, or zero on a restart.
  always_comb begin
    base = c_ext;
    case (s2_mode)
      MODE_MAC: base = s2_clr ? '0 : acc_ext;
      MODE_DOT: base = dot_first ? '0 : acc_ext;
      default:  base = c_ext;
    endcase
  end

  assign sum   = (s2_mode == MODE_SUB) ? (base - m_ext) : (base + m_ext);
  assign ovf_c = sum[P_W] ^ sum[P_W-1];
  assign p_c   = (ovf_c && s2_sat) ? (sum[P_W] ? p_min : p_max) : sum[P_W-1:0];

  // Update result, flags and the dot-product group counter; bubbles leave the accumulator alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      p         <= '0;
      ovf       <= 1'b0;
      dot_done  <= 1'b0;
      dot_cnt   <= '0;
      dot_len_q <= '0;
    end else if (adv) begin
      if (s2_vld) begin
        p   <= p_c;
        ovf <= ovf_c;
        if (s2_mode == MODE_DOT) begin
          out_valid <= dot_end;
          dot_done  <= dot_end;
          dot_cnt   <= dot_end ? '0 : cnt_nxt;
          if (dot_first) begin
            dot_len_q <= len_eff;
          end
        end else begin
          out_valid <= 1'b1;
          dot_done  <= 1'b0;
          dot_cnt   <= '0;
        end
      end else begin
        out_valid <= 1'b0;
        dot_done  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// Self-checking bench for dsp_mac_pipe: directed literal cases plus randomized traffic
// compared against a behavioural model of the arithmetic and dot-product grouping.
module tb_dsp_mac_pipe;

  localparam logic [1:0] M_MULT = 2'd0;
  localparam logic [1:0] M_MAC  = 2'd1;
  localparam logic [1:0] M_DOT  = 2'd2;
  localparam logic [1:0] M_SUB  = 2'd3;
  localparam longint PMAX = 64'sh0000_7FFF_FFFF_FFFF;
  localparam longint PMIN = -PMAX - 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [17:0] a = '0;
  logic [17:0] b = '0;
  logic [17:0] d = '0;
  logic [47:0] c = '0;
  logic        preadd_en = 1'b0;
  logic        preadd_sub = 1'b0;
  logic [1:0]  mode = M_MULT;
  logic        clr = 1'b0;
  logic        sat_en = 1'b0;
  logic [7:0]  dot_len = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [47:0] p;
  logic        ovf;
  logic        dot_done;

  always #5 clk = ~clk;

  dsp_mac_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .d(d), .c(c), .preadd_en(preadd_en), .preadd_sub(preadd_sub),
    .mode(mode), .clr(clr), .sat_en(sat_en), .dot_len(dot_len),
    .out_valid(out_valid), .out_ready(out_ready), .p(p), .ovf(ovf), .dot_done(dot_done)
  );

  typedef struct packed {
    logic [47:0] p;
    logic        ovf;
    logic        done;
  } res_t;

  res_t   exp_q[$];
  res_t   obs_q[$];
  res_t   cur;
  int     tests = 0;
  int     fails = 0;
  longint m_acc = 0;
  int     m_cnt = 0;
  int     m_len = 1;
  logic   stall_prev = 1'b0;
  logic [47:0] held_p = '0;
  logic   rnd_done = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_acc = 0;
    m_cnt = 0;
    m_len = 1;
    exp_q.delete();
    stall_prev = 1'b0;
  endtask

  // Behavioural model: exact signed arithmetic in 64 bits, then overflow/sat/wrap at 48 bits.
  task automatic model_beat();
    longint av, bv, dv, cv, pre, m, r;
    logic [63:0] rb;
    logic [47:0] pb;
    logic ov, done;
    av = longint'($signed(a));
    bv = longint'($signed(b));
    dv = longint'($signed(d));
    cv = longint'($signed(c));
    pre = preadd_en ? (preadd_sub ? dv - bv : dv + bv) : bv;
    m = av * pre;
    done = 1'b0;
    r = 0;
    case (mode)
      M_MULT: begin r = cv + m; m_cnt = 0; end
      M_SUB:  begin r = cv - m; m_cnt = 0; end
      M_MAC:  begin r = (clr ? 0 : m_acc) + m; m_cnt = 0; end
      default: begin
        if (clr || m_cnt == 0) begin
          m_len = (dot_len == 0) ? 1 : int'(dot_len);
          m_cnt = 1;
          r = m;
        end else begin
          m_cnt++;
          r = m_acc + m;
        end
        if (m_cnt == m_len) begin
          done = 1'b1;
          m_cnt = 0;
        end
      end
    endcase
    ov = (r > PMAX) || (r < PMIN);
    if (ov && sat_en) r = (r > PMAX) ? PMAX : PMIN;
    rb = r;
    pb = rb[47:0];
    m_acc = longint'($signed(pb));
    if (mode != M_DOT || done) exp_q.push_back({pb, ov, done});
  endtask

  // Compare process: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", in_ready, !out_valid || out_ready);
      if (stall_prev) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_p", p, held_p);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_out: got p=0x%0h with no result pending", p);
        end else begin
          cur = exp_q.pop_front();
          chk("out_p", p, cur.p);
          chk("out_ovf", ovf, cur.ovf);
          chk("out_done", dot_done, cur.done);
        end
        obs_q.push_back({p, ovf, dot_done});
      end
      stall_prev = out_valid && !out_ready;
      held_p = p;
      if (in_valid && in_ready) model_beat();
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic set_beat(input logic [1:0] md, input logic [17:0] av, input logic [17:0] bv,
                          input logic [17:0] dv, input logic [47:0] cv, input logic pe,
                          input logic ps, input logic cl, input logic sa, input logic [7:0] dl);
    mode = md; a = av; b = bv; d = dv; c = cv;
    preadd_en = pe; preadd_sub = ps; clr = cl; sat_en = sa; dot_len = dl;
  endtask

  // Hold the beat valid until it is accepted; returns just after the accepting edge.
  task automatic send();
    logic ok;
    in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      if (ok) return;
    end
    tests++;
    fails++;
    $display("FAIL accept_timeout: in_ready stayed 0, want 1 within 200 cycles");
  endtask

  task automatic beat(input logic [1:0] md, input logic [17:0] av, input logic [17:0] bv,
                      input logic [17:0] dv, input logic [47:0] cv, input logic pe,
                      input logic ps, input logic cl, input logic sa, input logic [7:0] dl);
    set_beat(md, av, bv, dv, cv, pe, ps, cl, sa, dl);
    send();
  endtask

  task automatic drain();
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #2;
      if (exp_q.size() == 0 && !out_valid) return;
    end
    tests++;
    fails++;
    $display("FAIL drain_timeout: %0d results still pending, want 0", exp_q.size());
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r0, r1, r2, r3, r4;
    logic [1:0]  rmd;
    int          run_left;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_p", p, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_done", dot_done, 0);
    chk("rst_in_ready", in_ready, 1);
    #1 rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;

    // Asynchronous reset in the middle of MAC traffic
    beat(M_MAC, 18'd100, 18'd3, 18'd0, 48'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
    beat(M_MAC, 18'd100, 18'd3, 18'd0, 48'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    beat(M_MAC, 18'd100, 18'd3, 18'd0, 48'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("pre_async_p_900", p, 48'd900);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_p", p, 0);
    chk("async_valid", out_valid, 0);
    chk("async_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #1;
    chk("held_rst_p", p, 0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    obs_q.delete();
    beat(M_MAC, 18'd3, 18'd4, 18'd0, 48'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    drain();
    chk("post_rst_count", obs_q.size(), 1);
    if (obs_q.size() >= 1) chk("post_rst_mac", obs_q[0].p, 48'd12);

    // MULT with pre-add, including latency
    obs_q.delete();
    beat(M_MULT, 18'd20, 18'd10, 18'd25, 48'd350, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    in_valid = 1'b0;
    chk("lat_edge1", out_valid, 0);
    @(posedge clk);
    #1;
    chk("lat_edge2", out_valid, 0);
    @(posedge clk);
    #1;
    chk("lat_edge3", out_valid, 1);
    chk("mult_p", p, 48'd1050);
    chk("mult_ovf", ovf, 0);
    drain();
    chk("mult_count", obs_q.size(), 1);

    // SUB with pre-subtract
    obs_q.delete();
    beat(M_SUB, 18'd20, 18'd10, 18'd25, 48'd350, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    beat(M_SUB, 18'd20, 18'd10, 18'd25, 48'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    drain();
    chk("sub_count", obs_q.size(), 2);
    if (obs_q.size() >= 2) begin
      chk("sub_p50", obs_q[0].p, 48'd50);
      chk("sub_m300", obs_q[1].p, 48'hFFFF_FFFF_FED4);
    end

    // MAC with back-pressure on the second result
    obs_q.delete();
    fork
      begin
        beat(M_MAC, 18'd5, 18'd6, 18'd0, 48'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
        for (int i = 0; i < 3; i++)
          beat(M_MAC, 18'd5, 18'd6, 18'd0, 48'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        in_valid = 1'b0;
      end
      begin
        for (int i = 0; i < 50; i++) begin
          @(posedge clk);
          if (obs_q.size() >= 1) break;
        end
        #1 out_ready = 1'b0;
        repeat (2) begin
          @(negedge clk);
          chk("bp_p60", p, 48'd60);
          chk("bp_in_ready", in_ready, 0);
          chk("bp_valid", out_valid, 1);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    chk("mac_count", obs_q.size(), 4);
    if (obs_q.size() >= 4) begin
      chk("mac_30", obs_q[0].p, 48'd30);
      chk("mac_60", obs_q[1].p, 48'd60);
      chk("mac_90", obs_q[2].p, 48'd90);
      chk("mac_120", obs_q[3].p, 48'd120);
    end

    // DOT groups of 3, then DOT_LEN=0
    obs_q.delete();
    beat(M_DOT, 18'd1, 18'd2, 18'd0, 48'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3);
    beat(M_DOT, 18'd2, 18'd2, 18'd0, 48'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3);
    beat(M_DOT, 18'd3, 18'd2, 18'd0, 48'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3);
    for (int i = 0; i < 3; i++)
      beat(M_DOT, 18'd4, 18'd2, 18'd0, 48'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3);
    drain();
    chk("dot_count", obs_q.size(), 2);
    if (obs_q.size() >= 2) begin
      chk("dot_p12", obs_q[0].p, 48'd12);
      chk("dot_done1", obs_q[0].done, 1);
      chk("dot_p24", obs_q[1].p, 48'd24);
      chk("dot_done2", obs_q[1].done, 1);
    end
    obs_q.delete();
    beat(M_DOT, 18'd7, 18'd3, 18'd0, 48'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    beat(M_DOT, 18'd5, 18'd3, 18'd0, 48'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    drain();
    chk("dot0_count", obs_q.size(), 2);
    if (obs_q.size() >= 2) begin
      chk("dot0_p21", obs_q[0].p, 48'd21);
      chk("dot0_p15", obs_q[1].p, 48'd15);
      chk("dot0_done", obs_q[1].done, 1);
    end

    // Saturation and wrap
    obs_q.delete();
    beat(M_MULT, 18'd1, 18'd1, 18'd0, 48'h7FFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
    beat(M_MULT, 18'd1, 18'd1, 18'd0, 48'h7FFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    drain();
    chk("sat_count", obs_q.size(), 2);
    if (obs_q.size() >= 2) begin
      chk("sat_p", obs_q[0].p, 48'h7FFF_FFFF_FFFF);
      chk("sat_ovf", obs_q[0].ovf, 1);
      chk("wrap_p", obs_q[1].p, 48'h8000_0000_0000);
      chk("wrap_ovf", obs_q[1].ovf, 1);
    end

    // Randomized traffic with random back-pressure and idle gaps
    run_left = 0;
    rmd = M_MULT;
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          if (run_left == 0) begin
            r0 = $urandom;
            rmd = r0[1:0];
            run_left = 1 + int'($urandom_range(0, 7));
          end
          run_left--;
          r0 = $urandom; r1 = $urandom; r2 = $urandom; r3 = $urandom; r4 = $urandom;
          set_beat(rmd, r0[17:0], r1[17:0], r2[17:0],
                   (r4[3:0] == 4'd0) ? {r4[31], {15{~r4[31]}}, r3} : {r4[15:0], r3},
                   r4[20], r4[21], (r4[26:24] == 3'd0), r4[22], 8'($urandom_range(0, 4)));
          send();
          if (r4[29:28] == 2'd0) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
          end
        end
        in_valid = 1'b0;
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    drain();
    chk("final_pending", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dsp_mac_pipe.md
Name:
dsp_mac_pipe

Overview:
- Parametrised, handshaked successor to the DSP48A1 slice: signed pre-add, multiply and post-add/accumulate datapath with generic widths.
- Adds modes the fixed slice lacks: running MAC, auto-clearing dot-product over DOT_LEN samples, optional saturation, and valid/ready back-pressure.
- Sits between sample sources (filters, correlators) and downstream result consumers.

Parameters:
- A_W, 18, width of A operand (signed).
- B_W, 18, width of B and D operands (signed).
- C_W, 48, width of C operand (signed, sign-extended to P_W).
- P_W, 48, width of result/accumulator; must be ≥ A_W+B_W+1 and ≥ C_W.
- LEN_W, 8, width of DOT_LEN.

Ports:
- CLK  in  1  rising-edge clock.
- RST_N  in  1  asynchronous active-low reset.
- IN_VALID  in  1  input beat valid.
- IN_READY  out  1  block can accept a beat; IN_READY = !OUT_VALID | OUT_READY.
- A  in  A_W  multiplier operand.
- B  in  B_W  pre-adder operand / multiplier operand.
- D  in  B_W  pre-adder operand.
- C  in  C_W  post-adder operand (MULT/SUB modes).
- PREADD_EN  in  1  1: multiplier uses the pre-adder result; 0: multiplier uses B.
- PREADD_SUB  in  1  pre-adder computes D-B when 1, D+B when 0.
- MODE  in  2  00 MULT, 01 MAC, 10 DOT, 11 SUB.
- CLR  in  1  this beat restarts the accumulator (MAC/DOT).
- SAT_EN  in  1  saturate on signed overflow.
- DOT_LEN  in  LEN_W  samples per dot product; 0 is treated as 1.
- OUT_VALID  out  1  result valid.
- OUT_READY  in  1  consumer accepts result.
- P  out  P_W  result / accumulator.
- OVF  out  1  signed overflow occurred on the beat shown in P.
- DOT_DONE  out  1  P holds a completed dot product.

Behaviour:
- Accept: IN_VALID & IN_READY at a rising CLK edge.
- Pipeline stages:
  - S1 registers A, B, D, C and all control fields.
  - S2 registers the pre-add and M = A × (PREADD_EN ? D±B : B). The pre-add result is B_W+1 bits; M is A_W+B_W+1 bits; all arithmetic is signed.
  - S3 registers P, OVF and DOT_DONE.
- Latency: result appears 3 cycles after accept (OUT_VALID rises on the 3rd edge).
- Global stall: while OUT_VALID & !OUT_READY, all stages and the counter hold and IN_READY=0. No beat is lost or duplicated.
- Bubbles: bubbles propagate with per-stage valid bits; a bubble never modifies the accumulator.
- S3 arithmetic, computed at P_W+1 bits:
  - MULT: P = sext(C) + sext(M).
  - SUB: P = sext(C) - sext(M).
  - MAC: P = (CLR ? 0 : P) + sext(M).
  - DOT: P = (first beat of group ? 0 : P) + sext(M).
- OVF=1 when the P_W+1-bit result does not fit in P_W signed bits.
  - SAT_EN=1: P is clamped to 2^(P_W-1)-1 or -2^(P_W-1), and the clamped value is the accumulator.
  - SAT_EN=0: P is wrapped to P_W bits.
- MULT/SUB/MAC: one OUT_VALID per accepted beat; DOT_DONE=0.
- DOT mode counter:
  - Counts S3 beats. DOT_LEN is latched on the first beat of a group.
  - Beats 1..N-1 update P with OUT_VALID=0.
  - Beat N updates P with OUT_VALID=1, DOT_DONE=1, and the counter returns to 0.
  - CLR on any DOT beat restarts the group at that beat (count=1).
  - A non-DOT beat reaching S3 resets the counter to 0.
- Simultaneous result handoff and new accept in the same cycle is legal (full throughput).
- Reset (RST_N low, asynchronous, any time including mid-operation or mid-group):
  - Immediately forces P=0, OVF=0, DOT_DONE=0, OUT_VALID=0.
  - Clears all stage valids, the counter and the accumulator.
  - IN_READY=1 during and after reset.
  - Registers leave reset on the first CLK edge after RST_N rises.

Test Plan:
1. Reset: async reset. Run MAC traffic, drop RST_N between edges -> P=0, OUT_VALID=0 with no clock edge; IN_READY=1; first post-reset beat behaves as CLR.
2. MULT with pre-add: MULT, PREADD_EN=1, PREADD_SUB=0, A=20, B=10, D=25, C=350 -> 3 cycles later P=1050, OVF=0, single OUT_VALID pulse.
3. SUB with pre-subtract: SUB, PREADD_EN=1, PREADD_SUB=1, A=20, B=10, D=25, C=350 -> P=50. Repeat with C=0 -> P=-300 (0xFFFF_FFFF_FED4).
4. MAC and back-pressure:
   - MAC, A=5, B=6, 4 back-to-back beats, CLR on the 1st -> P=30, 60, 90, 120.
   - Hold OUT_READY=0 for 2 cycles after the 2nd result -> P stays 60, IN_READY=0, and the remaining results still arrive in order.
5. DOT: DOT_LEN=3, B=2, A=1, 2, 3, then a 2nd group A=4, 4, 4 -> exactly two OUT_VALID pulses, P=12 then P=24, DOT_DONE=1 on each; DOT_LEN=0 -> every beat completes.
6. Saturation/wrap: MULT, C=0x7FFF_FFFF_FFFF, A=1, B=1.
   - SAT_EN=1 -> P=0x7FFF_FFFF_FFFF, OVF=1.
   - SAT_EN=0 -> P=0x8000_0000_0000, OVF=1.
